// File: rtl/encoder8to3_seq.sv
// rtl/encoder8to3_seq.sv - serial 8-to-3 priority encoder emitting one index per handshake
//
// Accepts an 8-bit request vector and emits the 3-bit index of each set bit,
// one per dout handshake, flagging the final index of the vector with dout_last.
//
// Parameters:
//   MSB_FIRST  0: lowest set bit first, 1: highest set bit first
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   en          gates acceptance of new vectors only
//   din         request vector
//   din_valid   din is presented
//   din_ready   block can accept din this cycle
//   dout        index of the current set bit
//   dout_valid  dout/dout_last valid
//   dout_ready  sink accepts dout this cycle
//   dout_last   current dout is the final index of the vector
//   dout_cnt    popcount of the most recently accepted vector

module encoder8to3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_last,
    output logic [3:0] dout_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pending;
    logic [7:0] pending_nxt;
    logic [7:0] remain;
    logic [2:0] dout_nxt;
    logic       dout_valid_nxt;
    logic       dout_last_nxt;
    logic [3:0] dout_cnt_nxt;
    logic       accept;
    logic       fire;

    // Index of the set bit that goes out first for this ordering.
    function automatic logic [2:0] pick_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic single_bit(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign din_ready = (state == IDLE) && en;
    assign accept    = din_valid && din_ready;
    assign fire      = dout_valid && dout_ready;

    // Pending set once the bit currently on dout has been consumed.
    assign remain    = pending & ~(8'd1 << dout);

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;
        dout_last_nxt  = dout_last;
        dout_cnt_nxt   = dout_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    dout_cnt_nxt = popcount(din);
                    // An all-zero vector updates the count but produces no beat.
                    if (din != 8'd0) begin
                        pending_nxt    = din;
                        dout_nxt       = pick_index(din);
                        dout_last_nxt  = single_bit(din);
                        dout_valid_nxt = 1'b1;
                        state_nxt      = EMIT;
                    end
                end
            end
            EMIT: begin
                if (fire) begin
                    if (dout_last) begin
                        pending_nxt    = 8'd0;
                        dout_valid_nxt = 1'b0;
                        dout_last_nxt  = 1'b0;
                        state_nxt      = IDLE;
                    end else begin
                        pending_nxt   = remain;
                        dout_nxt      = pick_index(remain);
                        dout_last_nxt = single_bit(remain);
                    end
                end
            end
            default: begin
                state_nxt      = IDLE;
                pending_nxt    = 8'd0;
                dout_valid_nxt = 1'b0;
                dout_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= 8'd0;
            dout       <= 3'd0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            dout_cnt   <= 4'd0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            dout_last  <= dout_last_nxt;
            dout_cnt   <= dout_cnt_nxt;
        end
    end

endmodule
